// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART byte feeder files.
//   UART_DATA_W  - width of one UART data byte
//   feed_state_e - feeder FSM states (idle, launch request, wait for frame end, idle gap)
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    FEED_IDLE     = 2'd0,
    FEED_LAUNCH   = 2'd1,
    FEED_WAIT_END = 2'd2,
    FEED_GAP      = 2'd3
  } feed_state_e;

endpackage

// File: rtl/uart_tx_feeder_if.sv
// uart_tx_feeder_if: the two handshakes around the byte feeder.
//   Producer side   : in_data, in_valid (to feeder), in_ready (from feeder)
//   Transmitter side: tx_start, tx_data (from feeder), tx_busy (to feeder)
//   modport slave  - the feeder's view
//   modport master - the surrounding environment (producer + transmitter)
interface uart_tx_feeder_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic                   tx_start;
  logic [UART_DATA_W-1:0] tx_data;
  logic                   tx_busy;

  modport master (
    output in_data, in_valid, tx_busy,
    input  in_ready, tx_start, tx_data
  );

  modport slave (
    input  in_data, in_valid, tx_busy,
    output in_ready, tx_start, tx_data
  );

endinterface

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: synchronous FIFO, DEPTH entries (power of 2, >= 2) of WIDTH bits.
//   clk, reset     - clock, synchronous active-high reset (empties the FIFO)
//   push, wr_data  - write request and data; ignored when full
//   pop, rd_data   - read request and head entry; ignored when empty
//   count          - registered number of stored entries
//   full           - count == DEPTH
//   empty          - read side has nothing to offer; a freshly written entry
//                    becomes readable one cycle after its write edge
module uart_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_ZERO = (AW+1)'(1'b0);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1'b1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [AW-1:0] PTR_ZERO = AW'(1'b0);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             avail_q, avail_d;
  logic             push_ok_s, pop_ok_s;

  assign full      = (count_q == CNT_FULL);
  assign empty     = ~avail_q;
  assign count     = count_q;
  assign rd_data   = mem_q[rd_ptr_q];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & avail_q;

  // Next-state for pointers, occupancy and the read-side availability flag.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;   // AW-bit pointers wrap modulo DEPTH
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // Availability looks at the count before this edge's write, so a new
    // entry is offered one cycle after it lands (write-to-read latency).
    avail_d = (count_q != CNT_ZERO) && !(pop_ok_s && (count_q == CNT_ONE));
  end

  // Control registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
      avail_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      avail_q  <= avail_d;
    end
  end

  // Storage array; contents need no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers producer bytes and launches one transmitter frame per byte.
//   clk, reset  - clock, synchronous active-high reset
//   bus (slave) - in_data/in_valid/in_ready producer handshake,
//                 tx_start/tx_data/tx_busy transmitter handshake
//   fifo_count  - bytes currently buffered
//   idle        - FSM idle, FIFO empty and transmitter not busy
//   launch_err  - one-cycle pulse when a launch is abandoned (timeout build only)
// Optional feature macro: UART_TX_FEEDER_TIMEOUT_EN enables the launch timeout
// (LAUNCH_TIMEOUT cycles without tx_busy drops the byte and pulses launch_err).
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH          = 16,
  parameter int GAP_CYCLES     = 0,
  parameter int LAUNCH_TIMEOUT = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  uart_tx_feeder_if.slave        bus,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   idle
`ifdef UART_TX_FEEDER_TIMEOUT_EN
  ,
  output logic                   launch_err
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ZERO = CW'(1'b0);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  feed_state_e            state_q, state_d;
  logic                   tx_start_q, tx_start_d;
  logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
  logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
  logic                   pop_s;
  logic                   push_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [UART_DATA_W-1:0] fifo_rd_data_s;

`ifdef UART_TX_FEEDER_TIMEOUT_EN
  localparam int TW = (LAUNCH_TIMEOUT > 1) ? $clog2(LAUNCH_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(LAUNCH_TIMEOUT - 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          launch_err_q, launch_err_d;
  assign launch_err = launch_err_q;
`else
  localparam int unused_launch_timeout = LAUNCH_TIMEOUT;
`endif

  // A full FIFO refuses even if a pop happens the same edge.
  assign bus.in_ready = ~fifo_full_s;
  assign push_s       = bus.in_valid & ~fifo_full_s;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;
  assign idle         = (state_q == FEED_IDLE) && (fifo_count == CNT_ZERO) && !bus.tx_busy;

  uart_byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_s),
    .wr_data (bus.in_data),
    .pop     (pop_s),
    .rd_data (fifo_rd_data_s),
    .count   (fifo_count),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Feeder FSM next-state and output decode.
  always_comb begin
    state_d    = state_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;
    gap_cnt_d  = gap_cnt_q;
    pop_s      = 1'b0;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    to_cnt_d     = to_cnt_q;
    launch_err_d = 1'b0;
`endif
    case (state_q)
      FEED_IDLE: begin
        // tx_busy guard: a frame started before a reset must finish first.
        if (!fifo_empty_s && !bus.tx_busy) begin
          pop_s      = 1'b1;
          tx_data_d  = fifo_rd_data_s;
          tx_start_d = 1'b1;
          state_d    = FEED_LAUNCH;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
          to_cnt_d   = TW'(1'b0);
`endif
        end else begin
          tx_start_d = 1'b0;
        end
      end
      FEED_LAUNCH: begin
        if (bus.tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = FEED_WAIT_END;
        end
`ifdef UART_TX_FEEDER_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          // Transmitter never acknowledged: drop this byte, do not retry.
          tx_start_d   = 1'b0;
          launch_err_d = 1'b1;
          state_d      = FEED_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1'b1);
        end
`else
        else begin
          tx_start_d = 1'b1;
        end
`endif
      end
      FEED_WAIT_END: begin
        if (!bus.tx_busy) begin
          if (GAP_CYCLES > 0) begin
            gap_cnt_d = GW'(1'b0);
            state_d   = FEED_GAP;
          end else begin
            state_d = FEED_IDLE;
          end
        end else begin
          state_d = FEED_WAIT_END;
        end
      end
      FEED_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = FEED_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1'b1);
        end
      end
      default: begin
        state_d    = FEED_IDLE;
        tx_start_d = 1'b0;
      end
    endcase
  end

  // Feeder FSM state and registered transmitter outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FEED_IDLE;
      tx_start_q <= 1'b0;
      tx_data_q  <= {UART_DATA_W{1'b0}};
      gap_cnt_q  <= GW'(1'b0);
`ifdef UART_TX_FEEDER_TIMEOUT_EN
      to_cnt_q     <= TW'(1'b0);
      launch_err_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      gap_cnt_q  <= gap_cnt_d;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
      launch_err_q <= launch_err_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: scoreboard bench for uart_tx_feeder.
// Two instances: dut (DEPTH 16, no gap) and gdut (DEPTH 4, GAP_CYCLES 5,
// LAUNCH_TIMEOUT 8). Each has a small transmitter model that raises busy two
// cycles after it sees tx_start and pops the expected byte from a queue.
`timescale 1ns/1ps
module tb_uart_tx_feeder;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  // Cycle counter used for gap measurement.
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  uart_tx_feeder_if bus ();
  uart_tx_feeder_if gbus ();
  logic [4:0] fifo_count;
  logic [2:0] g_fifo_count;
  logic       idle, g_idle;
`ifdef UART_TX_FEEDER_TIMEOUT_EN
  logic       launch_err, g_launch_err;
`endif

  uart_tx_feeder #(.DEPTH(16), .GAP_CYCLES(0), .LAUNCH_TIMEOUT(1024)) dut (
    .clk(clk), .reset(reset), .bus(bus), .fifo_count(fifo_count), .idle(idle)
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    , .launch_err(launch_err)
`endif
  );

  uart_tx_feeder #(.DEPTH(4), .GAP_CYCLES(5), .LAUNCH_TIMEOUT(8)) gdut (
    .clk(clk), .reset(reset), .bus(gbus), .fifo_count(g_fifo_count), .idle(g_idle)
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    , .launch_err(g_launch_err)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- transmitter model for dut ----------------
  logic [7:0] sb_q[$];
  bit         m_stall = 1'b0;
  bit         m_track = 1'b0;
  int         m_phase = 0;
  int         m_cnt   = 0;
  logic [7:0] m_byte;

  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (m_phase == 0) begin
        if (!m_stall && bus.tx_start) begin
          m_byte  = bus.tx_data;
          m_track = 1'b1;
          if (sb_q.size() == 0) check_eq("sb_underflow", 32'd1, 32'd0);
          else check_eq("tx_data_order", bus.tx_data, sb_q.pop_front());
          m_phase = 1;
          m_cnt   = 2;
        end
      end else begin
        if (m_track) check_eq("tx_data_hold", bus.tx_data, m_byte);
        m_cnt--;
        if (m_cnt == 0) begin
          if (m_phase == 1) begin
            bus.tx_busy = 1'b1; m_phase = 2; m_cnt = 10;
          end else begin
            bus.tx_busy = 1'b0; m_phase = 0;
          end
        end
      end
    end
  end

  // ---------------- transmitter model for gdut ----------------
  logic [7:0]  gq[$];
  int unsigned g_starts[$];
  int unsigned g_falls[$];
  bit          g_stall = 1'b0;
  int          g_phase = 0;
  int          g_cnt   = 0;

  initial begin
    gbus.tx_busy = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (g_phase == 0) begin
        if (!g_stall && gbus.tx_start) begin
          g_starts.push_back(cyc);
          if (gq.size() == 0) check_eq("g_sb_underflow", 32'd1, 32'd0);
          else check_eq("g_tx_data_order", gbus.tx_data, gq.pop_front());
          g_phase = 1;
          g_cnt   = 2;
        end
      end else begin
        g_cnt--;
        if (g_cnt == 0) begin
          if (g_phase == 1) begin
            gbus.tx_busy = 1'b1; g_phase = 2; g_cnt = 3;
          end else begin
            gbus.tx_busy = 1'b0; g_phase = 0; g_falls.push_back(cyc);
          end
        end
      end
    end
  end

  task automatic push_main(input logic [7:0] d);
    check_eq("push_ready", bus.in_ready, 32'd1);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    sb_q.push_back(d);
  endtask

  task automatic push_gap(input logic [7:0] d, input bit track);
    check_eq("g_push_ready", gbus.in_ready, 32'd1);
    gbus.in_data  = d;
    gbus.in_valid = 1'b1;
    @(posedge clk); #1;
    gbus.in_valid = 1'b0;
    if (track) gq.push_back(d);
  endtask

  task automatic wait_main_drained(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (idle && sb_q.size() == 0 && m_phase == 0) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq(tag, done, 32'd1);
  endtask

  // Global time limit so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    reset = 1'b1;
    bus.in_valid  = 1'b0; bus.in_data  = 8'h00;
    gbus.in_valid = 1'b0; gbus.in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset values
    check_eq("rst_tx_start", bus.tx_start, 32'd0);
    check_eq("rst_tx_data", bus.tx_data, 32'h00);
    check_eq("rst_fifo_count", fifo_count, 32'd0);
    check_eq("rst_in_ready", bus.in_ready, 32'd1);
    check_eq("rst_idle", idle, 32'd1);
`ifdef UART_TX_FEEDER_TIMEOUT_EN
    check_eq("rst_launch_err", launch_err, 32'd0);
`endif

    // Single byte: minimum latency k+2, tx_start drops after busy is seen
    push_main(8'hA5);                       // now after edge k
    check_eq("lat_k_count", fifo_count, 32'd1);
    check_eq("lat_k_start", bus.tx_start, 32'd0);
    @(posedge clk); #1;                     // k+1
    check_eq("lat_k1_start", bus.tx_start, 32'd0);
    @(posedge clk); #1;                     // k+2
    check_eq("lat_k2_start", bus.tx_start, 32'd1);
    check_eq("lat_k2_data", bus.tx_data, 32'hA5);
    check_eq("lat_k2_count", fifo_count, 32'd0);
    @(posedge clk); #1;
    check_eq("launch_hold1", bus.tx_start, 32'd1);
    @(posedge clk); #1;
    check_eq("launch_hold2", bus.tx_start, 32'd1);
    @(posedge clk); #1;                     // busy sampled high at this edge
    check_eq("launch_drop", bus.tx_start, 32'd0);
    check_eq("busy_not_idle", idle, 32'd0);
    wait_main_drained("single_idle");

    // Fill to full behind a blocked launch (model never acknowledges)
    m_stall = 1'b1;
    push_main(8'hEE);
    repeat (3) begin @(posedge clk); #1; end
    check_eq("blocker_start", bus.tx_start, 32'd1);
    check_eq("blocker_count", fifo_count, 32'd0);
    for (int i = 0; i < 16; i++) push_main(8'(i));
    check_eq("full_count", fifo_count, 32'd16);
    check_eq("full_ready", bus.in_ready, 32'd0);
    bus.in_data  = 8'h10;
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check_eq("full_reject_count", fifo_count, 32'd16);
    end

    // Release: pop at full while in_valid is held
    m_stall = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (fifo_count != 5'd16) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("popfull_seen", seen, 32'd1);
    check_eq("popfull_count", fifo_count, 32'd15);
    check_eq("popfull_ready", bus.in_ready, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    sb_q.push_back(8'h10);
    check_eq("popfull_refill", fifo_count, 32'd16);
    wait_main_drained("fill_drain");

    // Reset mid-frame with 3 bytes queued
    for (int i = 0; i < 4; i++) push_main(8'h50 + 8'(i));
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.tx_busy) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq("midrst_busy_seen", seen, 32'd1);
    check_eq("midrst_queued", fifo_count, 32'd3);
    reset   = 1'b1;
    m_track = 1'b0;
    sb_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    check_eq("midrst_count", fifo_count, 32'd0);
    check_eq("midrst_start", bus.tx_start, 32'd0);
    check_eq("midrst_ready", bus.in_ready, 32'd1);
    push_main(8'h3C);
    n = 0;
    while (bus.tx_busy && n < 20) begin
      check_eq("midrst_guard", bus.tx_start, 32'd0);
      @(posedge clk); #1;
      n++;
    end
    check_eq("midrst_busy_fell", bus.tx_busy, 32'd0);
    wait_main_drained("midrst_resume");

    // GAP_CYCLES=5, two back-to-back bytes
    push_gap(8'hA1, 1'b1);
    push_gap(8'hA2, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (g_starts.size() == 2 && g_phase == 0 && g_idle) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("gap_done", seen, 32'd1);
    if (g_starts.size() == 2 && g_falls.size() >= 1)
      check_eq("gap_spacing", g_starts[1] - g_falls[0], 32'd7);
    else
      check_eq("gap_records", g_starts.size(), 32'd2);
    check_eq("gap_sb_empty", gq.size(), 32'd0);

`ifdef UART_TX_FEEDER_TIMEOUT_EN
    // Launch timeout: model never asserts busy
    g_stall = 1'b1;
    push_gap(8'hC1, 1'b0);
    push_gap(8'hC2, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (gbus.tx_start) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq("to_start_seen", seen, 32'd1);
    check_eq("to_first_data", gbus.tx_data, 32'hC1);
    n = 1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (g_launch_err) begin
        seen = 1'b1;
        break;
      end
      if (gbus.tx_start) n++;
    end
    check_eq("to_err_seen", seen, 32'd1);
    check_eq("to_start_cycles", n, 32'd8);
    check_eq("to_start_drop", gbus.tx_start, 32'd0);
    @(posedge clk); #1;
    check_eq("to_err_pulse", g_launch_err, 32'd0);
    check_eq("to_next_start", gbus.tx_start, 32'd1);
    check_eq("to_next_data", gbus.tx_data, 32'hC2);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (g_launch_err) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("to_err2_seen", seen, 32'd1);
    @(posedge clk); #1;
    check_eq("to_idle", g_idle, 32'd1);
    g_stall = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
